// File: rtl/dot_product_seq_if.sv
// rtl/dot_product_seq_if.sv - bus bundle between the dot-product sequencer and its environment
// Groups the control handshake, data-memory read port and ALU operand port.
//   start/a_base/b_base/len    : operation request
//   busy/done/result/zero      : operation status and registered result
//   mem_addr/mem_rd_en         : memory read request, mem_rdata one cycle later
//   alu_in1/alu_in2/alu_op     : ALU operands, alu_out/alu_z returned combinationally
// Modport master is the sequencer view; modport slave is the environment view.
interface dot_product_seq_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_rdata;
  logic [15:0]       alu_in1;
  logic [15:0]       alu_in2;
  logic [2:0]        alu_op;
  logic [15:0]       alu_out;
  logic [1:0]        alu_z;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  logic              zero;

  modport master (
    input  start, a_base, b_base, len, mem_rdata, alu_out, alu_z,
    output mem_addr, mem_rd_en, alu_in1, alu_in2, alu_op, busy, done, result, zero
  );

  modport slave (
    output start, a_base, b_base, len, mem_rdata, alu_out, alu_z,
    input  mem_addr, mem_rd_en, alu_in1, alu_in2, alu_op, busy, done, result, zero
  );
endinterface

// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - sequencer computing a 16-bit dot product through an external ALU
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : dot_product_seq_if.master (request, memory read port, ALU port, status)
// Each element takes RD_A, RD_B, MUL, ACC; DONE publishes the result and zero flag.
module dot_product_seq #(
  parameter int ADDR_W = 8
) (
  input logic              clk,
  input logic              rst,
  dot_product_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MUL  = 3'd3,
    ACC  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd4;

  state_t            state;
  logic [ADDR_W-1:0] a_b;
  logic [ADDR_W-1:0] b_b;
  logic [ADDR_W-1:0] n;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       opa;
  logic [15:0]       prod;
  logic [15:0]       acc;

  // Only the low zero-flag bit carries meaning for this block.
  logic unused_alu_z;
  assign unused_alu_z = bus.alu_z[1];

  // Control outputs are registered: each branch below sets the values that
  // belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_b           <= '0;
      b_b           <= '0;
      n             <= '0;
      idx           <= '0;
      opa           <= '0;
      prod          <= '0;
      acc           <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.alu_op    <= OP_ADD;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.alu_op    <= OP_ADD;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_b      <= bus.a_base;
            b_b      <= bus.b_base;
            n        <= bus.len;
            idx      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            if (bus.len != '0) begin
              state         <= RD_A;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= bus.a_base;
            end else begin
              state      <= DONE;
              bus.alu_op <= OP_PASS;
              bus.done   <= 1'b1;
            end
          end
        end
        RD_A: begin
          state         <= RD_B;
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= b_b + idx;
        end
        RD_B: begin
          // mem_rdata now holds the A element requested in RD_A.
          opa        <= bus.mem_rdata;
          state      <= MUL;
          bus.alu_op <= OP_MUL;
        end
        MUL: begin
          prod  <= bus.alu_out;
          state <= ACC;
        end
        ACC: begin
          acc <= bus.alu_out;
          idx <= idx + ADDR_W'(1);
          if (idx == n - ADDR_W'(1)) begin
            state      <= DONE;
            bus.alu_op <= OP_PASS;
            bus.done   <= 1'b1;
          end else begin
            state         <= RD_A;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= a_b + idx + ADDR_W'(1);
          end
        end
        DONE: begin
          bus.result <= acc;
          bus.zero   <= bus.alu_z[0];
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Operand muxes stay combinational: in MUL the B element is only present on
  // mem_rdata during that very cycle.
  always_comb begin
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;
    case (state)
      MUL: begin
        bus.alu_in1 = opa;
        bus.alu_in2 = bus.mem_rdata;
      end
      ACC: begin
        bus.alu_in1 = acc;
        bus.alu_in2 = prod;
      end
      DONE: begin
        bus.alu_in2 = acc;
      end
      default: ;
    endcase
  end

endmodule
